carpma_hakem: RTL and testbench

CARPMA_HAKEM -- requirements
Module: carpma_hakem

---
 rtl/carpma_paket.sv | 20 ++
 rtl/carpma_cekirdek.sv | 68 ++++++
 rtl/carpma_hakem.sv | 129 ++++++++++++
 tb/tb_carpma_hakem.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/carpma_paket.sv
// rtl/carpma_paket.sv - shared types and constants for the Booth multiplier arbiter
//
// Contents: FSM state enum, operand width, step-counter width, and the
// kimlik values that tag a result as belonging to requester A or B.

package carpma_paket;

    localparam int GENISLIK       = 32;
    localparam int SAYAC_GENISLIK = 5;

    localparam logic KIMLIK_A = 1'b0;
    localparam logic KIMLIK_B = 1'b1;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        SONUC   = 2'd2
    } durum_t;

endpackage

// File: rtl/carpma_cekirdek.sv
// rtl/carpma_cekirdek.sv - radix-2 Booth multiplier datapath, one step per cycle
//
// Ports:
//   saat, reset      clock, asynchronous active-high reset
//   yukle            load multiplicand/multiplier and clear the accumulator
//   adim             perform one Booth step this cycle
//   carpilan, carpan 32-bit signed multiplicand / multiplier
//   carpim           64-bit signed product (valid after 32 steps)

module carpma_cekirdek
    import carpma_paket::*;
(
    input  logic                    saat,
    input  logic                    reset,
    input  logic                    yukle,
    input  logic                    adim,
    input  logic [GENISLIK-1:0]     carpilan,
    input  logic [GENISLIK-1:0]     carpan,
    output logic [2*GENISLIK-1:0]   carpim
);

    // The upper half carries one guard bit so that negating the most negative
    // multiplicand (-2^31) stays representable; {ust, alt} is the 65-bit
    // accumulator and q_eksi is the implicit bit to the right of alt[0].
    logic [GENISLIK:0]   ust;
    logic [GENISLIK-1:0] alt;
    logic                q_eksi;
    logic [GENISLIK-1:0] m;

    logic [GENISLIK:0]   m_gen;
    logic [GENISLIK:0]   topla;
    logic [1:0]          cift;

    assign m_gen = {m[GENISLIK-1], m};
    // Pair is read as {previous bit, current bit}: 01 marks the start of a run
    // of ones (subtract), 10 marks its end (add).
    assign cift  = {q_eksi, alt[0]};

    always_comb begin
        topla = ust;
        case (cift)
            2'b01:   topla = ust - m_gen;
            2'b10:   topla = ust + m_gen;
            default: topla = ust;
        endcase
    end

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            ust    <= '0;
            alt    <= '0;
            q_eksi <= 1'b0;
            m      <= '0;
        end else if (yukle) begin
            ust    <= '0;
            alt    <= carpan;
            q_eksi <= 1'b0;
            m      <= carpilan;
        end else if (adim) begin
            ust    <= {topla[GENISLIK], topla[GENISLIK:1]};
            alt    <= {topla[0], alt[GENISLIK-1:1]};
            q_eksi <= alt[0];
        end
    end

    assign carpim = {ust[GENISLIK-1:0], alt};

endmodule

// File: rtl/carpma_hakem.sv
// rtl/carpma_hakem.sv - two-requester round-robin front end for the Booth multiplier
//
// Ports:
//   saat, reset                  clock, asynchronous active-high reset
//   istek_a, istek_b             requester A/B has an operation pending
//   sayi1_a, sayi2_a             requester A operands (signed 32-bit)
//   sayi1_b, sayi2_b             requester B operands (signed 32-bit)
//   kabul_a, kabul_b             accept pulse, high only in BOSTA on the accepting cycle
//   sonuc                        64-bit signed product
//   sonuc_kimlik                 0 = A, 1 = B
//   sonuc_gecerli, sonuc_hazir   result valid/ready handshake
//   tasma                        product outside signed 32-bit range
//   mesgul                       state is not BOSTA
// Macro CARPMA_TASMA_EN: enables the tasma overflow flag; otherwise tasma is 0.

module carpma_hakem
    import carpma_paket::*;
(
    input  logic                    saat,
    input  logic                    reset,
    input  logic                    istek_a,
    input  logic                    istek_b,
    input  logic [GENISLIK-1:0]     sayi1_a,
    input  logic [GENISLIK-1:0]     sayi2_a,
    input  logic [GENISLIK-1:0]     sayi1_b,
    input  logic [GENISLIK-1:0]     sayi2_b,
    output logic                    kabul_a,
    output logic                    kabul_b,
    output logic [2*GENISLIK-1:0]   sonuc,
    output logic                    sonuc_kimlik,
    output logic                    sonuc_gecerli,
    input  logic                    sonuc_hazir,
    output logic                    tasma,
    output logic                    mesgul
);

    durum_t durum, sonraki;

    logic [SAYAC_GENISLIK-1:0] sayac;
    logic                      kimlik;
    logic                      son_hizmet;
    logic                      secim_b;
    logic                      yukle;
    logic                      adim;
    logic [GENISLIK-1:0]       carpilan;
    logic [GENISLIK-1:0]       carpan;

    // B wins when alone, or when both ask and A was served last.
    assign secim_b  = istek_b && (!istek_a || (son_hizmet == KIMLIK_A));
    assign carpilan = secim_b ? sayi1_b : sayi1_a;
    assign carpan   = secim_b ? sayi2_b : sayi2_a;

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            durum <= BOSTA;
        end else begin
            durum <= sonraki;
        end
    end

    always_comb begin
        sonraki = durum;
        kabul_a = 1'b0;
        kabul_b = 1'b0;
        yukle   = 1'b0;
        adim    = 1'b0;
        case (durum)
            BOSTA: begin
                // kabul is combinational so it can never leak past BOSTA;
                // gating with reset keeps it low while reset is held.
                if (!reset && (istek_a || istek_b)) begin
                    yukle   = 1'b1;
                    kabul_a = !secim_b;
                    kabul_b = secim_b;
                    sonraki = HESAPLA;
                end
            end
            HESAPLA: begin
                adim = 1'b1;
                if (sayac == {SAYAC_GENISLIK{1'b1}}) begin
                    sonraki = SONUC;
                end
            end
            SONUC: begin
                if (sonuc_hazir) begin
                    sonraki = BOSTA;
                end
            end
            default: sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            sayac      <= '0;
            kimlik     <= KIMLIK_A;
            son_hizmet <= KIMLIK_B;
        end else if (yukle) begin
            sayac      <= '0;
            kimlik     <= secim_b;
            son_hizmet <= secim_b;
        end else if (adim) begin
            sayac      <= sayac + SAYAC_GENISLIK'(1);
        end
    end

    carpma_cekirdek u_cekirdek (
        .saat     (saat),
        .reset    (reset),
        .yukle    (yukle),
        .adim     (adim),
        .carpilan (carpilan),
        .carpan   (carpan),
        .carpim   (sonuc)
    );

    assign sonuc_kimlik  = kimlik;
    assign sonuc_gecerli = (durum == SONUC);
    assign mesgul        = (durum != BOSTA);

`ifdef CARPMA_TASMA_EN
    // Fits in signed 32 bits only when bits 63..31 are all copies of the sign.
    assign tasma = (durum == SONUC) &&
                   !((&sonuc[2*GENISLIK-1:GENISLIK-1]) || !(|sonuc[2*GENISLIK-1:GENISLIK-1]));
`else
    assign tasma = 1'b0;
`endif

endmodule

// File: tb/tb_carpma_hakem.sv
// tb/tb_carpma_hakem.sv - directed self-checking bench for carpma_hakem

module tb_carpma_hakem;

`ifdef CARPMA_TASMA_EN
    localparam logic TASMA_EN = 1'b1;
`else
    localparam logic TASMA_EN = 1'b0;
`endif

    logic        saat = 1'b0;
    logic        reset;
    logic        istek_a, istek_b;
    logic [31:0] sayi1_a, sayi2_a, sayi1_b, sayi2_b;
    logic        kabul_a, kabul_b;
    logic [63:0] sonuc;
    logic        sonuc_kimlik;
    logic        sonuc_gecerli;
    logic        sonuc_hazir;
    logic        tasma;
    logic        mesgul;

    int hata   = 0;
    int toplam = 0;

    always #5 saat = ~saat;

    carpma_hakem dut (
        .saat          (saat),
        .reset         (reset),
        .istek_a       (istek_a),
        .istek_b       (istek_b),
        .sayi1_a       (sayi1_a),
        .sayi2_a       (sayi2_a),
        .sayi1_b       (sayi1_b),
        .sayi2_b       (sayi2_b),
        .kabul_a       (kabul_a),
        .kabul_b       (kabul_b),
        .sonuc         (sonuc),
        .sonuc_kimlik  (sonuc_kimlik),
        .sonuc_gecerli (sonuc_gecerli),
        .sonuc_hazir   (sonuc_hazir),
        .tasma         (tasma),
        .mesgul        (mesgul)
    );

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hata++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", etiket, gozlenen, beklenen);
        end
    endtask

    // Called #1 after the accepting edge; counts edges until sonuc_gecerli.
    task automatic bekle_sonuc(input string etiket, input logic [63:0] beklenen,
                               input logic kimlik_bek, input logic tasma_bek);
        int gecen;
        gecen = 0;
        kontrol({etiket, " kabul_a after accept"}, 64'(kabul_a), 64'd0);
        kontrol({etiket, " mesgul in HESAPLA"}, 64'(mesgul), 64'd1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge saat);
            #1;
            if (sonuc_gecerli) begin
                gecen = n;
                break;
            end
        end
        kontrol({etiket, " latency"}, 64'(gecen), 64'd32);
        kontrol({etiket, " sonuc"}, sonuc, beklenen);
        kontrol({etiket, " kimlik"}, 64'(sonuc_kimlik), 64'(kimlik_bek));
        kontrol({etiket, " tasma"}, 64'(tasma), 64'(tasma_bek));
    endtask

    task automatic birak(input string etiket);
        @(negedge saat);
        sonuc_hazir = 1'b1;
        @(posedge saat);
        #1;
        sonuc_hazir = 1'b0;
        kontrol({etiket, " mesgul after hazir"}, 64'(mesgul), 64'd0);
        kontrol({etiket, " gecerli after hazir"}, 64'(sonuc_gecerli), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        istek_a     = 1'b1;
        istek_b     = 1'b0;
        sayi1_a     = '0; sayi2_a = '0; sayi1_b = '0; sayi2_b = '0;
        sonuc_hazir = 1'b0;
        repeat (3) @(negedge saat);
        #1;
        kontrol("reset kabul_a", 64'(kabul_a), 64'd0);
        kontrol("reset mesgul", 64'(mesgul), 64'd0);
        kontrol("reset gecerli", 64'(sonuc_gecerli), 64'd0);
        kontrol("reset sonuc", sonuc, 64'd0);
        kontrol("reset kimlik", 64'(sonuc_kimlik), 64'd0);
        kontrol("reset tasma", 64'(tasma), 64'd0);
        istek_a = 1'b0;
        @(negedge saat);
        reset = 1'b0;

        // Simultaneous request right after reset: A first, then B.
        @(negedge saat);
        sayi1_a = 32'd5;  sayi2_a = 32'd6;
        sayi1_b = -32'sd2; sayi2_b = 32'd4;
        istek_a = 1'b1; istek_b = 1'b1;
        #1;
        kontrol("tie1 kabul_a", 64'(kabul_a), 64'd1);
        kontrol("tie1 kabul_b", 64'(kabul_b), 64'd0);
        @(posedge saat);
        #1;
        istek_a = 1'b0;
        kontrol("tie1 kabul_b in HESAPLA", 64'(kabul_b), 64'd0);
        bekle_sonuc("5x6", 64'd30, 1'b0, 1'b0);
        kontrol("5x6 kabul_b in SONUC", 64'(kabul_b), 64'd0);
        birak("5x6");
        kontrol("B kabul after release", 64'(kabul_b), 64'd1);
        @(posedge saat);
        #1;
        istek_b = 1'b0;
        bekle_sonuc("-2x4", 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0);
        birak("-2x4");

        // Next tie goes to A; also exercises the overflow flag.
        @(negedge saat);
        sayi1_a = 32'd3; sayi2_a = 32'd4;
        sayi1_b = 32'h0001_0000; sayi2_b = 32'h0001_0000;
        istek_a = 1'b1; istek_b = 1'b1;
        #1;
        kontrol("tie2 kabul_a", 64'(kabul_a), 64'd1);
        kontrol("tie2 kabul_b", 64'(kabul_b), 64'd0);
        @(posedge saat);
        #1;
        istek_a = 1'b0;
        bekle_sonuc("3x4", 64'd12, 1'b0, 1'b0);
        birak("3x4");
        kontrol("tie2 B kabul", 64'(kabul_b), 64'd1);
        @(posedge saat);
        #1;
        istek_b = 1'b0;
        bekle_sonuc("2^16x2^16", 64'h0000_0001_0000_0000, 1'b1, TASMA_EN);
        birak("2^16x2^16");

        // Lone request from A.
        @(negedge saat);
        sayi1_a = 32'd7; sayi2_a = -32'sd3;
        istek_a = 1'b1;
        #1;
        kontrol("7x-3 kabul_a", 64'(kabul_a), 64'd1);
        @(posedge saat);
        #1;
        istek_a = 1'b0;
        bekle_sonuc("7x-3", 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
        birak("7x-3");

        // Lone B with most-negative operands, then backpressure with A waiting.
        @(negedge saat);
        sayi1_b = 32'h8000_0000; sayi2_b = 32'h8000_0000;
        istek_b = 1'b1;
        #1;
        kontrol("min kabul_b", 64'(kabul_b), 64'd1);
        @(posedge saat);
        #1;
        istek_b = 1'b0;
        bekle_sonuc("minxmin", 64'h4000_0000_0000_0000, 1'b1, TASMA_EN);
        @(negedge saat);
        sayi1_a = 32'h7FFF_FFFF; sayi2_a = 32'hFFFF_FFFF;
        istek_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge saat);
            kontrol("bp sonuc", sonuc, 64'h4000_0000_0000_0000);
            kontrol("bp mesgul", 64'(mesgul), 64'd1);
            kontrol("bp kabul_a", 64'(kabul_a), 64'd0);
            kontrol("bp kimlik", 64'(sonuc_kimlik), 64'd1);
        end
        birak("bp");
        kontrol("bp A kabul", 64'(kabul_a), 64'd1);
        @(posedge saat);
        #1;
        istek_a = 1'b0;
        bekle_sonuc("maxx-1", 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0);
        birak("maxx-1");

        // Reset at step 15 of HESAPLA aborts the operation.
        @(negedge saat);
        sayi1_a = 32'd100; sayi2_a = 32'd200;
        istek_a = 1'b1;
        @(posedge saat);
        #1;
        istek_a = 1'b0;
        repeat (15) @(posedge saat);
        @(negedge saat);
        reset = 1'b1;
        #1;
        kontrol("abort mesgul", 64'(mesgul), 64'd0);
        kontrol("abort sonuc", sonuc, 64'd0);
        kontrol("abort kimlik", 64'(sonuc_kimlik), 64'd0);
        kontrol("abort gecerli", 64'(sonuc_gecerli), 64'd0);
        kontrol("abort kabul_a", 64'(kabul_a), 64'd0);
        @(negedge saat);
        reset = 1'b0;
        begin
            int gorulen;
            gorulen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge saat);
                if (sonuc_gecerli || mesgul) gorulen++;
            end
            kontrol("abort no result", 64'(gorulen), 64'd0);
        end

        // Recovery after reset: lone B.
        @(negedge saat);
        sayi1_b = 32'd2; sayi2_b = 32'd3;
        istek_b = 1'b1;
        #1;
        kontrol("recover kabul_b", 64'(kabul_b), 64'd1);
        @(posedge saat);
        #1;
        istek_b = 1'b0;
        bekle_sonuc("2x3", 64'd6, 1'b1, 1'b0);
        birak("2x3");

        $display("Result: errors=%0d of %0d checks", hata, toplam);
        $finish;
    end

endmodule
